// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA coordinate type, default 640x480@60 timing and a span helper
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // true when lo <= v < lo + len
    function automatic logic in_span(input coord_t v, input int lo, input int len);
        return (int'(v) >= lo) && (int'(v) < lo + len);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: enabled up-counter 0..MAX with a combinational wrap flag
module wrap_counter #(
    parameter int MAX   = 1,
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = en && (count == WIDTH'(MAX));

    // advance on en, returning to zero after MAX
    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + WIDTH'(1);
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator (pixel strobe, position, syncs, blank, frame pulse)
// Optional VGA_FRAME_COUNT_EN adds a 16-bit frame_count that steps with frame_start.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP
) (
    input  logic        clock,
    input  logic        reset,
    output logic        pix_en,
    output coord_t      col,
    output coord_t      row,
    output logic        HS,
    output logic        VS,
    output logic        blank,
    output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV) + 1;

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             h_wrap;
    logic             v_en;
    logic             v_wrap;
    coord_t           col_next;
    coord_t           row_next;
    logic             div_unused;

    // the divider phase itself is not needed outside the strobe
    assign div_unused = ^div_cnt;
    assign v_en       = h_wrap & pix_en;

    wrap_counter #(.MAX(CLK_DIV - 1), .WIDTH(DIV_W)) u_div (
        .clock(clock),
        .reset(reset),
        .en   (1'b1),
        .count(div_cnt),
        .wrap (div_wrap)
    );

    wrap_counter #(.MAX(H_TOTAL - 1), .WIDTH(10)) u_h (
        .clock(clock),
        .reset(reset),
        .en   (pix_en),
        .count(col),
        .wrap (h_wrap)
    );

    wrap_counter #(.MAX(V_TOTAL - 1), .WIDTH(10)) u_v (
        .clock(clock),
        .reset(reset),
        .en   (v_en),
        .count(row),
        .wrap (v_wrap)
    );

    // position the counters will hold after this edge, so decode lines up with row/col
    always_comb begin
        col_next = h_wrap ? '0 : pix_en ? col + 10'd1 : col;
        row_next = v_wrap ? '0 : v_en ? row + 10'd1 : row;
    end

    // registered strobe, syncs, blank and frame pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_en      <= 1'b0;
            HS          <= 1'b1;
            VS          <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= div_wrap;
            HS          <= !in_span(col_next, H_VISIBLE + H_FP, H_SYNC);
            VS          <= !in_span(row_next, V_VISIBLE + V_FP, V_SYNC);
            blank       <= (col_next >= 10'(H_VISIBLE)) || (row_next >= 10'(V_VISIBLE));
            frame_start <= v_wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // frame counter steps on the same edge that raises frame_start
    always_ff @(posedge clock) begin
        if (reset)
            frame_count <= '0;
        else if (v_wrap)
            frame_count <= frame_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized-reset scoreboard bench for three vga_sync_gen configurations
module tb_vga_sync_gen;
    import vga_pkg::*;

    typedef struct packed {
        logic [9:0]  col;
        logic [9:0]  row;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        pix;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef obs_t [2:0] trio_t;

    localparam int D   [3] = '{2, 1, 3};
    localparam int HV  [3] = '{VGA_H_VISIBLE, 20, 20};
    localparam int HFP [3] = '{VGA_H_FP, 3, 3};
    localparam int HSY [3] = '{VGA_H_SYNC, 5, 5};
    localparam int HBP [3] = '{VGA_H_BP, 4, 4};
    localparam int VV  [3] = '{VGA_V_VISIBLE, 12, 12};
    localparam int VFP [3] = '{VGA_V_FP, 2, 2};
    localparam int VSY [3] = '{VGA_V_SYNC, 2, 2};
    localparam int VBP [3] = '{VGA_V_BP, 3, 3};

    logic        clock;
    logic        reset;
    logic        pe    [3];
    coord_t      cl    [3];
    coord_t      rw    [3];
    logic        hs_o  [3];
    logic        vs_o  [3];
    logic        bl    [3];
    logic        fs_o  [3];
    logic [15:0] fc    [3];

    trio_t sb[$];
    int    tq[$];
    int    t;
    int    checks;
    int    failures;
    bit    done;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        vga_sync_gen #(
            .CLK_DIV(D[g]), .H_VISIBLE(HV[g]), .H_FP(HFP[g]), .H_SYNC(HSY[g]), .H_BP(HBP[g]),
            .V_VISIBLE(VV[g]), .V_FP(VFP[g]), .V_SYNC(VSY[g]), .V_BP(VBP[g])
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .pix_en     (pe[g]),
            .col        (cl[g]),
            .row        (rw[g]),
            .HS         (hs_o[g]),
            .VS         (vs_o[g]),
            .blank      (bl[g]),
            .frame_start(fs_o[g])
`ifdef VGA_FRAME_COUNT_EN
            ,
            .frame_count(fc[g])
`endif
        );
`ifndef VGA_FRAME_COUNT_EN
        assign fc[g] = '0;
`endif
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // closed-form view: after t edges since reset, floor((t-1)/D) pixel strobes have taken effect
    function automatic obs_t model(input int k, input int tt);
        obs_t e;
        int   ht, vt, frame, n, p, c, r;
        bit   adv;
        ht    = HV[k] + HFP[k] + HSY[k] + HBP[k];
        vt    = VV[k] + VFP[k] + VSY[k] + VBP[k];
        frame = ht * vt;
        n     = (tt >= 1) ? (tt - 1) / D[k] : 0;
        adv   = (tt >= 2) && ((tt - 1) % D[k] == 0);
        p     = n % frame;
        c     = p % ht;
        r     = p / ht;
        e.col   = 10'(c);
        e.row   = 10'(r);
        e.hs    = !(c >= HV[k] + HFP[k] && c < HV[k] + HFP[k] + HSY[k]);
        e.vs    = !(r >= VV[k] + VFP[k] && r < VV[k] + VFP[k] + VSY[k]);
        e.blank = (c >= HV[k]) || (r >= VV[k]);
        e.pix   = (tt >= 1) && (tt % D[k] == 0);
        e.fs    = adv && (p == 0);
`ifdef VGA_FRAME_COUNT_EN
        e.fc    = 16'(n / frame);
`else
        e.fc    = '0;
`endif
        return e;
    endfunction

    task automatic step(input bit r);
        trio_t e;
        reset = r;
        @(posedge clock);
        t = r ? 0 : t + 1;
        for (int k = 0; k < 3; k++) e[k] = model(k, t);
        sb.push_back(e);
        tq.push_back(t);
        #1;
    endtask

    initial begin : stim
        t      = 0;
        done   = 1'b0;
        reset  = 1'b1;
        repeat (3) step(1'b1);
        repeat (6000) step(1'b0);
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(40, 2500)) step(1'b0);
            repeat ($urandom_range(1, 3)) step(1'b1);
        end
        repeat (4000) step(1'b0);
        done = 1'b1;
    end

    initial begin : mon
        trio_t e;
        obs_t  a;
        int    et;
        int    vis     [3];
        bit    started [3];
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 3; k++) begin
            vis[k]     = 0;
            started[k] = 1'b0;
        end
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                et = tq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    a = '{col: cl[k], row: rw[k], hs: hs_o[k], vs: vs_o[k], blank: bl[k],
                          pix: pe[k], fs: fs_o[k], fc: fc[k]};
                    checks++;
                    if (a !== e[k]) begin
                        failures++;
                        if (failures <= 20)
                            $display("FAIL timing dut%0d t=%0d got col=%0d row=%0d hs=%b vs=%b blank=%b pix=%b fs=%b fc=%0d req col=%0d row=%0d hs=%b vs=%b blank=%b pix=%b fs=%b fc=%0d",
                                     k, et, a.col, a.row, a.hs, a.vs, a.blank, a.pix, a.fs, a.fc,
                                     e[k].col, e[k].row, e[k].hs, e[k].vs, e[k].blank, e[k].pix, e[k].fs, e[k].fc);
                    end
                    if (et == 0) begin
                        started[k] = 1'b0;
                        vis[k]     = 0;
                    end
                    if (k > 0 && fs_o[k] === 1'b1) begin
                        if (started[k]) begin
                            checks++;
                            if (vis[k] != HV[k] * VV[k]) begin
                                failures++;
                                $display("FAIL visible_count dut%0d got %0d req %0d", k, vis[k], HV[k] * VV[k]);
                            end
                        end
                        started[k] = 1'b1;
                        vis[k]     = 0;
                    end
                    if (pe[k] === 1'b1 && bl[k] === 1'b0) vis[k]++;
                end
            end
        end
    end

    initial begin : fin
        wait (done == 1'b1);
        repeat (4) @(negedge clock);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending req 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got timeout req finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
